// File: rtl/l2_miss_request_arbiter_pkg.sv
// Shared defines for the L2 miss request path: line/entry index types, the
// request id layout ({source, entry idx}) and the requester encodings.
package l2_miss_request_arbiter_pkg;

  localparam int L2_SRC_W   = 2;
  localparam int LINE_IDX_W = 20;
  localparam int L1_ENTRY_W = 3;

  typedef logic [LINE_IDX_W-1:0] cache_line_index_t;
  typedef logic [L1_ENTRY_W-1:0] l1_miss_entry_idx_t;
  typedef logic [L2_SRC_W-1:0]   l2_src_t;

  localparam l2_src_t L2_SRC_ICACHE = 2'd0;
  localparam l2_src_t L2_SRC_DCACHE = 2'd1;
  localparam l2_src_t L2_SRC_STORE  = 2'd2;

  typedef struct packed {
    l2_src_t            source;
    l1_miss_entry_idx_t idx;
  } l2_request_id_t;

endpackage

// File: rtl/l2_miss_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when update_en is set.
module rr_arbiter
  import l2_miss_request_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  l2_src_t    ptr_q;
  l2_src_t    ptr_d;
  l2_src_t    win;
  l2_src_t    cand;
  logic [2:0] sum3;
  logic       found;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    sum3  = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // Circular index ptr+k folded back into 0..N-1 without a divider
      sum3 = {1'b0, ptr_q} + 3'(k);
      if (sum3 >= 3'(N)) sum3 = sum3 - 3'(N);
      cand = sum3[1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win         = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_en && found) begin
      ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/l2_miss_request_arbiter.sv
// Arbitrates L1 miss queues onto a single credit-limited L2 request port and
// routes L2 responses back to the originating queue one cycle later.
module l2_miss_request_arbiter
  import l2_miss_request_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int NUM_SRC         = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                src_ready,
  input  cache_line_index_t [NUM_SRC-1:0]   src_adr,
  input  l1_miss_entry_idx_t [NUM_SRC-1:0]  src_idx,
  input  logic [NUM_SRC-1:0]                src_sync,
  output logic [NUM_SRC-1:0]                src_ack,
  output logic                              l2_request_valid,
  output cache_line_index_t                 l2_request_adr,
  output l2_request_id_t                    l2_request_id,
  output logic                              l2_request_sync,
  input  logic                              l2_ready,
  input  logic                              l2_response_valid,
  input  l2_request_id_t                    l2_response_id,
  output logic [NUM_SRC-1:0]                src_response_valid,
  output l1_miss_entry_idx_t                src_response_idx
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef logic [3:0] cred_t;
  localparam cred_t CRED_MAX = cred_t'(MAX_OUTSTANDING);

  logic [0:0]         state_q,    state_d;
  cred_t              credits_q,  credits_d;
  cache_line_index_t  adr_q,      adr_d;
  l2_request_id_t     id_q,       id_d;
  logic               sync_q,     sync_d;
  logic [NUM_SRC-1:0] rsp_v_q,    rsp_v_d;
  l1_miss_entry_idx_t rsp_idx_q,  rsp_idx_d;

  logic [NUM_SRC-1:0] rr_grant;
  logic               resp_ok;
  logic               issue_ok;
  logic               grant_en;
  l2_src_t            win_src;
  cache_line_index_t  win_adr;
  l1_miss_entry_idx_t win_idx;
  logic               win_sync;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (src_ready),
    .update_en (grant_en),
    .grant     (rr_grant)
  );

  // Responses for unknown sources or beyond the credit pool are discarded
  always_comb begin
    resp_ok  = l2_response_valid
            && (int'(l2_response_id.source) < NUM_SRC)
            && (credits_q != CRED_MAX);
    issue_ok = (state_q == ST_IDLE) || l2_ready;
    // A same-cycle returning credit lets a grant go out even at zero credits
    grant_en = reset && issue_ok && ((credits_q != '0) || resp_ok) && (|src_ready);
    src_ack  = grant_en ? rr_grant : '0;
  end

  always_comb begin
    win_src  = '0;
    win_adr  = '0;
    win_idx  = '0;
    win_sync = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (rr_grant[s]) begin
        win_src  = l2_src_t'(s);
        win_adr  = src_adr[s];
        win_idx  = src_idx[s];
        win_sync = src_sync[s];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    id_d    = id_q;
    sync_d  = sync_q;
    if (grant_en) begin
      state_d   = ST_HOLD;
      adr_d     = win_adr;
      id_d      = '{source: win_src, idx: win_idx};
      sync_d    = win_sync;
    end else if ((state_q == ST_HOLD) && l2_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({grant_en, resp_ok})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    rsp_v_d   = '0;
    rsp_idx_d = '0;
    if (resp_ok) begin
      rsp_v_d[l2_response_id.source] = 1'b1;
      rsp_idx_d                      = l2_response_id.idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      credits_q <= CRED_MAX;
      adr_q     <= '0;
      id_q      <= '0;
      sync_q    <= 1'b0;
      rsp_v_q   <= '0;
      rsp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      adr_q     <= adr_d;
      id_q      <= id_d;
      sync_q    <= sync_d;
      rsp_v_q   <= rsp_v_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  assign l2_request_valid   = (state_q == ST_HOLD);
  assign l2_request_adr     = adr_q;
  assign l2_request_id      = id_q;
  assign l2_request_sync    = sync_q;
  assign src_response_valid = rsp_v_q;
  assign src_response_idx   = rsp_idx_q;

endmodule

// File: tb/tb_l2_miss_request_arbiter.sv
// Directed bench: a default-credit instance driven from a vector table plus
// a two-credit instance exercised by hand-written credit sequences.
module tb_l2_miss_request_arbiter;
  import l2_miss_request_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  cache_line_index_t [2:0]  src_adr;
  l1_miss_entry_idx_t [2:0] src_idx;
  logic [2:0]               src_sync;

  cache_line_index_t  adr_of [3] = '{20'h000A0, 20'h00123, 20'h003C3};
  l1_miss_entry_idx_t idx_of [3] = '{3'd5, 3'd2, 3'd7};
  logic               sync_of[3] = '{1'b1, 1'b0, 1'b1};

  logic [2:0]         a_ready, a_ack, a_srsp;
  logic               a_l2v, a_l2sync, a_l2rdy, a_rspv;
  cache_line_index_t  a_l2adr;
  l2_request_id_t     a_l2id, a_rspid;
  l1_miss_entry_idx_t a_sidx;

  logic [2:0]         c_ready, c_ack, c_srsp;
  logic               c_l2v, c_l2sync, c_l2rdy, c_rspv;
  cache_line_index_t  c_l2adr;
  l2_request_id_t     c_l2id, c_rspid;
  l1_miss_entry_idx_t c_sidx;

  l2_miss_request_arbiter #(.MAX_OUTSTANDING(8), .NUM_SRC(3)) dut_a (
    .clk(clk), .reset(reset), .src_ready(a_ready), .src_adr(src_adr),
    .src_idx(src_idx), .src_sync(src_sync), .src_ack(a_ack),
    .l2_request_valid(a_l2v), .l2_request_adr(a_l2adr), .l2_request_id(a_l2id),
    .l2_request_sync(a_l2sync), .l2_ready(a_l2rdy), .l2_response_valid(a_rspv),
    .l2_response_id(a_rspid), .src_response_valid(a_srsp), .src_response_idx(a_sidx)
  );

  l2_miss_request_arbiter #(.MAX_OUTSTANDING(2), .NUM_SRC(3)) dut_c (
    .clk(clk), .reset(reset), .src_ready(c_ready), .src_adr(src_adr),
    .src_idx(src_idx), .src_sync(src_sync), .src_ack(c_ack),
    .l2_request_valid(c_l2v), .l2_request_adr(c_l2adr), .l2_request_id(c_l2id),
    .l2_request_sync(c_l2sync), .l2_ready(c_l2rdy), .l2_response_valid(c_rspv),
    .l2_response_id(c_rspid), .src_response_valid(c_srsp), .src_response_idx(c_sidx)
  );

  typedef struct {
    logic [2:0] ready;
    logic       l2rdy;
    logic       rspv;
    logic [4:0] rspid;
    logic [2:0] ack;
    logic       l2v;
    int         src;
    logic [2:0] srsp;
    logic [2:0] sidx;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [2:0] ready, input logic l2rdy, input logic rspv,
                              input logic [4:0] rspid, input logic [2:0] ack, input logic l2v,
                              input int src, input logic [2:0] srsp, input logic [2:0] sidx);
    vec_t v;
    v.ready = ready; v.l2rdy = l2rdy; v.rspv = rspv; v.rspid = rspid; v.ack = ack;
    v.l2v = l2v; v.src = src; v.srsp = srsp; v.sidx = sidx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_row(input int i, input vec_t v);
    @(negedge clk);
    a_ready = v.ready; a_l2rdy = v.l2rdy; a_rspv = v.rspv; a_rspid = v.rspid;
    #1;
    check($sformatf("row%0d ack", i), 32'(a_ack), 32'(v.ack));
    @(posedge clk);
    #1;
    check($sformatf("row%0d l2v", i), 32'(a_l2v), 32'(v.l2v));
    if (v.l2v) begin
      check($sformatf("row%0d id", i), 32'(a_l2id), {27'd0, 2'(v.src), idx_of[v.src]});
      check($sformatf("row%0d adr", i), 32'(a_l2adr), 32'(adr_of[v.src]));
      check($sformatf("row%0d sync", i), 32'(a_l2sync), 32'(sync_of[v.src]));
    end
    check($sformatf("row%0d srsp", i), 32'(a_srsp), 32'(v.srsp));
    check($sformatf("row%0d sidx", i), 32'(a_sidx), 32'(v.sidx));
  endtask

  task automatic step_c(input string name, input logic [2:0] ready, input logic rspv,
                        input logic [4:0] rspid, input logic [2:0] exp_ack,
                        input logic [2:0] exp_srsp, input logic [2:0] exp_sidx);
    @(negedge clk);
    c_ready = ready; c_l2rdy = 1'b1; c_rspv = rspv; c_rspid = rspid;
    #1;
    check({name, " ack"}, 32'(c_ack), 32'(exp_ack));
    @(posedge clk);
    #1;
    check({name, " srsp"}, 32'(c_srsp), 32'(exp_srsp));
    if (exp_srsp != 3'b000) check({name, " sidx"}, 32'(c_sidx), 32'(exp_sidx));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " ack"},  32'(a_ack),    32'd0);
    check({name, " l2v"},  32'(a_l2v),    32'd0);
    check({name, " adr"},  32'(a_l2adr),  32'd0);
    check({name, " id"},   32'(a_l2id),   32'd0);
    check({name, " sync"}, 32'(a_l2sync), 32'd0);
    check({name, " srsp"}, 32'(a_srsp),   32'd0);
    check({name, " sidx"}, 32'(a_sidx),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      src_adr[i]  = adr_of[i];
      src_idx[i]  = idx_of[i];
      src_sync[i] = sync_of[i];
    end
    reset = 1'b0;
    a_ready = 3'b111; a_l2rdy = 1'b1; a_rspv = 1'b1; a_rspid = 5'b00001;
    c_ready = 3'b111; c_l2rdy = 1'b1; c_rspv = 1'b0; c_rspid = '0;

    // Reset held with live stimulus: everything must stay quiet
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    check("in_reset c_ack", 32'(c_ack), 32'd0);
    a_ready = '0; a_l2rdy = 1'b0; a_rspv = 1'b0; a_rspid = '0;
    c_ready = '0; c_l2rdy = 1'b0;
    reset = 1'b1;

    // ready, l2rdy, rspv, rspid, ack, l2v, src, srsp, sidx
    vq.push_back(mk(3'b000, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b0, 0, 3'b000, 3'd0)); // full-credit response dropped
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b001, 1'b1, 0, 3'b000, 3'd0)); // fairness 0,1,2,0,1,2
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b010, 1'b1, 1, 3'b000, 3'd0));
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b100, 1'b1, 2, 3'b000, 3'd0));
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b001, 1'b1, 0, 3'b000, 3'd0));
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b010, 1'b1, 1, 3'b000, 3'd0));
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b100, 1'b1, 2, 3'b000, 3'd0));
    vq.push_back(mk(3'b000, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 0, 3'b000, 3'd0)); // accepted, idle
    vq.push_back(mk(3'b000, 1'b0, 1'b1, 5'b00001, 3'b000, 1'b0, 0, 3'b001, 3'd1)); // response {0,1}
    vq.push_back(mk(3'b010, 1'b1, 1'b0, 5'b00000, 3'b010, 1'b1, 1, 3'b000, 3'd0)); // single source 0x123
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(3'b111, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1, 3'b000, 3'd0)); // back-pressure
    vq.push_back(mk(3'b111, 1'b1, 1'b0, 5'b00000, 3'b100, 1'b1, 2, 3'b000, 3'd0)); // accept + regrant
    vq.push_back(mk(3'b000, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 0, 3'b000, 3'd0));
    vq.push_back(mk(3'b000, 1'b0, 1'b1, 5'b11000, 3'b000, 1'b0, 0, 3'b000, 3'd0)); // source 3 dropped
    vq.push_back(mk(3'b000, 1'b0, 1'b1, 5'b10100, 3'b000, 1'b0, 0, 3'b100, 3'd4)); // response {2,4}

    foreach (vq[i]) run_row(i, vq[i]);
    @(negedge clk);
    a_ready = '0; a_l2rdy = 1'b0; a_rspv = 1'b0; a_rspid = '0;

    // Two-credit instance: stall, credit return, and same-cycle grant/response
    step_c("c1",  3'b001, 1'b0, 5'b00000, 3'b001, 3'b000, 3'd0);
    step_c("c2",  3'b001, 1'b0, 5'b00000, 3'b001, 3'b000, 3'd0);
    step_c("c3",  3'b001, 1'b0, 5'b00000, 3'b000, 3'b000, 3'd0);
    step_c("c4",  3'b001, 1'b0, 5'b00000, 3'b000, 3'b000, 3'd0);
    step_c("c5",  3'b000, 1'b1, 5'b00001, 3'b000, 3'b001, 3'd1);
    step_c("c6",  3'b001, 1'b0, 5'b00000, 3'b001, 3'b000, 3'd0);
    step_c("c7",  3'b001, 1'b0, 5'b00000, 3'b000, 3'b000, 3'd0);
    step_c("c8",  3'b010, 1'b1, 5'b01011, 3'b010, 3'b010, 3'd3);
    check("c8 l2v", 32'(c_l2v), 32'd1);
    check("c8 id",  32'(c_l2id), {27'd0, 2'd1, idx_of[1]});
    step_c("c9",  3'b010, 1'b0, 5'b00000, 3'b000, 3'b000, 3'd0);
    step_c("c10", 3'b010, 1'b1, 5'b11000, 3'b000, 3'b000, 3'd0);
    step_c("c11", 3'b010, 1'b0, 5'b00000, 3'b000, 3'b000, 3'd0);
    @(negedge clk);
    c_ready = '0; c_rspv = 1'b0; c_rspid = '0;

    // Reset while a request is held: request is lost, pointer and credits restored
    a_ready = 3'b010; a_l2rdy = 1'b0;
    #1 check("hold ack", 32'(a_ack), 32'b010);
    @(posedge clk);
    #1 check("hold l2v", 32'(a_l2v), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("mid_hold");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_hold2");
    a_ready = '0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d l2v", k), 32'(a_l2v), 32'd0);
      check($sformatf("post_rst%0d ack", k), 32'(a_ack), 32'd0);
      check($sformatf("post_rst%0d srsp", k), 32'(a_srsp), 32'd0);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      a_ready = 3'b111; a_l2rdy = 1'b1;
      #1;
      check($sformatf("refill%0d ack", k), 32'(a_ack),
            (k < 8) ? 32'(3'b001 << (k % 3)) : 32'd0);
    end
    @(negedge clk);
    a_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_miss_request_arbiter.md
L2_MISS_REQUEST_ARBITER -- requirements
Module: l2_miss_request_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: max L2 requests in flight (range 1..15).
REQ-002 SHALL have parameter NUM_SRC, default 3: requester count (0=icache load miss queue, 1=dcache load miss queue, 2=store queue).
REQ-003 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- src_ready  input  NUM_SRC  per-source dequeue_ready.
- src_adr  input  NUM_SRC x cache_line_index_t  per-source dequeue address.
- src_idx  input  NUM_SRC x l1_miss_entry_idx_t  per-source entry index.
- src_sync  input  NUM_SRC  per-source synchronized flag.
- src_ack  output  NUM_SRC  one-hot dequeue_ack pulse.
- l2_request_valid  output  1  request held for L2.
- l2_request_adr  output  cache_line_index_t  request address.
- l2_request_id  output  l2_request_id_t  {source, entry idx}.
- l2_request_sync  output  1  synchronized flag.
- l2_ready  input  1  L2 accepts request this cycle.
- l2_response_valid  input  1  L2 response strobe.
- l2_response_id  input  l2_request_id_t  id of completed request.
- src_response_valid  output  NUM_SRC  per-source response pulse.
- src_response_idx  output  l1_miss_entry_idx_t  entry index, shared by all sources.

Function
REQ-004 SHALL implement FSM IDLE/HOLD: IDLE has no request held; HOLD has l2_request_valid=1.
REQ-005 SHALL grant only if credits>0 and some src_ready=1.
- Winner: first ready source at or after rr_ptr, circular.
- Winner's src_ack SHALL be 1 for that cycle only.
- Winner's adr/idx/sync/source SHALL be captured into the output register at the clock edge; state goes to HOLD.
REQ-006 SHALL keep l2_request_* stable in HOLD until l2_ready=1; the request is accepted on that edge.
REQ-007 On acceptance, SHALL re-grant in the same cycle if REQ-005 holds (stays HOLD, one request per cycle); otherwise SHALL go to IDLE.
REQ-008 SHALL never grant in HOLD unless l2_ready=1 that cycle; src_ack SHALL be at most one-hot.
REQ-009 After each grant, SHALL set rr_ptr to (winner+1) mod NUM_SRC.
REQ-010 Credit counter:
- starts at MAX_OUTSTANDING;
- decrements on grant;
- increments on a valid response;
- on grant and valid response in the same cycle, SHALL stay unchanged and the grant is permitted even when credits=0.
REQ-011 On l2_response_valid, SHALL pulse src_response_valid[source] one cycle later with src_response_idx = idx field; latency 1, no back-pressure.
REQ-012 A response with source >= NUM_SRC SHALL be dropped: no pulse, no credit change.
REQ-013 A response while credits=MAX_OUTSTANDING SHALL be dropped (overflow guard).
REQ-014 src_ack SHALL be combinational from registered state and src_ready only; it SHALL NOT depend on src_adr, src_idx or src_sync.

Reset
REQ-015 While reset=0, SHALL hold:
- state=IDLE, l2_request_valid=0, l2_request_adr/id/sync=0;
- src_ack=0, src_response_valid=0, src_response_idx=0;
- rr_ptr=0, credits=MAX_OUTSTANDING.
REQ-016 Reset asserted mid-HOLD SHALL discard the held request; no src_ack or response pulse SHALL follow deassertion until new stimulus.

Structure
REQ-017 l2_request_id_t, L2_SRC_ICACHE/L2_SRC_DCACHE/L2_SRC_STORE and the source-field width (2 bits) SHALL live in the shared defines package; cache_line_index_t and l1_miss_entry_idx_t SHALL come from there.
REQ-018 Round-robin selection SHALL be a sub-module, rr_arbiter (request vector, update enable, one-hot grant).

Verification
REQ-019 Single source: src_ready[1]=1, adr=0x123, idx=2, l2_ready=1.
- src_ack[1] pulses once.
- Next cycle: l2_request_valid=1, adr=0x123, id={1,2}.
REQ-020 Fairness: all three src_ready held 1, l2_ready=1 from reset.
- Grant order 0,1,2,0,1,2; one request per cycle.
REQ-021 Back-pressure: l2_ready=0 for 5 cycles with a held request.
- Outputs stable; src_ack=0 throughout.
- On l2_ready=1, next grant occurs that cycle.
REQ-022 Credits: MAX_OUTSTANDING=2, no responses.
- Exactly 2 grants, then stall.
- Response id={0,1} gives src_response_valid[0]=1 and idx=1 one cycle later.
- Third grant follows.
REQ-023 Simultaneous grant and response at credits=0: grant occurs and credits stay 0; response id={3,0} gives no pulse.
REQ-024 Reset=0 mid-HOLD, then release: l2_request_valid=0, rr_ptr=0, credits=MAX_OUTSTANDING.
